// File: rtl/conv1d_cmd_sequencer.sv
// conv1d_cmd_sequencer
//   Autonomous initiator for one conv1d CFU command port. On a go pulse it
//   streams the kernel rows into the kernel buffer, writes zero-padded input
//   rows into the input buffer, programs bias and offset, starts the
//   convolution, waits for the output buffer and then reads the packed
//   results out over a ready/valid result stream.
//
// Ports
//   clk, reset_n             clock, asynchronous active-low reset
//   go                       start pulse, honoured only when idle
//   cfg_len/words/bias/offset run configuration, latched on go
//   s_valid/s_ready/s_data   source stream: kernel words, then input words
//   cu_cmd/cu_inp0/cu_inp1   registered conv1d command bus (cmd 0 = NOP)
//   cu_valid_in, cu_ret      conv1d output-buffer valid and read data
//   m_valid/m_ready/m_data   result stream, four packed outputs per word
//   busy, done               run in progress / one-cycle completion pulse
module conv1d_cmd_sequencer #(
    parameter int KERNEL_LEN = 8,
    parameter int PAD        = 4,
    parameter int ROW_STRIDE = 128,
    parameter int LEN_W      = 11
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             go,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic [5:0]       cfg_words,
    input  logic [31:0]      cfg_bias,
    input  logic [31:0]      cfg_offset,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [31:0]      s_data,
    output logic [6:0]       cu_cmd,
    output logic [31:0]      cu_inp0,
    output logic [31:0]      cu_inp1,
    input  logic             cu_valid_in,
    input  logic [31:0]      cu_ret,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [31:0]      m_data,
    output logic             busy,
    output logic             done
);

    // One extra bit so the last padded row (2*PAD + max len - 1) fits.
    localparam int ROW_W = LEN_W + 1;

    localparam logic [6:0] CMD_NOP    = 7'd0;
    localparam logic [6:0] CMD_WR_IN  = 7'd1;
    localparam logic [6:0] CMD_WR_K   = 7'd2;
    localparam logic [6:0] CMD_RD     = 7'd3;
    localparam logic [6:0] CMD_START  = 7'd4;
    localparam logic [6:0] CMD_BIAS   = 7'd7;
    localparam logic [6:0] CMD_OFFSET = 7'd8;

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_KERNEL = 4'd1;
    localparam logic [3:0] S_HEAD   = 4'd2;
    localparam logic [3:0] S_INPUT  = 4'd3;
    localparam logic [3:0] S_TAIL   = 4'd4;
    localparam logic [3:0] S_BIAS   = 4'd5;
    localparam logic [3:0] S_OFFSET = 4'd6;
    localparam logic [3:0] S_START  = 4'd7;
    localparam logic [3:0] S_WAIT   = 4'd8;
    localparam logic [3:0] S_RDREQ  = 4'd9;
    localparam logic [3:0] S_RDCAP  = 4'd10;
    localparam logic [3:0] S_HOLD   = 4'd11;
    localparam logic [3:0] S_DONE   = 4'd12;

    localparam logic [ROW_W-1:0] KERN_LAST = ROW_W'(KERNEL_LEN - 1);
    localparam logic [ROW_W-1:0] HEAD_LAST = ROW_W'(PAD - 1);

    logic [3:0]       state_q, state_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [5:0]       word_q, word_d;
    logic [LEN_W-1:0] k_q, k_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [5:0]       words_q, words_d;
    logic [31:0]      bias_q, bias_d;
    logic [31:0]      offset_q, offset_d;
    logic [6:0]       cmd_q, cmd_d;
    logic [31:0]      inp0_q, inp0_d;
    logic [31:0]      inp1_q, inp1_d;
    logic             m_valid_q, m_valid_d;
    logic [31:0]      m_data_q, m_data_d;

    logic             last_word;
    logic [ROW_W-1:0] row_adv;
    logic [5:0]       word_adv;
    logic [31:0]      addr;
    logic [ROW_W-1:0] in_last, tail_last, nreads, k_next;

    // Column counter walks the words of a row; row advances on its wrap.
    assign last_word = (word_q == words_q - 6'd1);
    assign row_adv   = last_word ? row_q + ROW_W'(1) : row_q;
    assign word_adv  = last_word ? 6'd0 : word_q + 6'd1;
    assign addr      = 32'(row_q) * 32'(ROW_STRIDE) + {24'd0, word_q, 2'b00};

    // Input rows follow the head padding; the tail padding follows the input.
    assign in_last   = ROW_W'(PAD) + {1'b0, len_q} - ROW_W'(1);
    assign tail_last = in_last + ROW_W'(PAD);
    assign nreads    = ({1'b0, len_q} + ROW_W'(3)) >> 2;
    assign k_next    = {1'b0, k_q} + ROW_W'(1);

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        word_d    = word_q;
        k_d       = k_q;
        len_d     = len_q;
        words_d   = words_q;
        bias_d    = bias_q;
        offset_d  = offset_q;
        cmd_d     = CMD_NOP;
        inp0_d    = '0;
        inp1_d    = '0;
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        case (state_q)
            S_IDLE: begin
                if (go) begin
                    len_d    = cfg_len;
                    words_d  = cfg_words;
                    bias_d   = cfg_bias;
                    offset_d = cfg_offset;
                    row_d    = '0;
                    word_d   = '0;
                    k_d      = '0;
                    state_d  = S_KERNEL;
                end
            end
            S_KERNEL: begin
                if (s_valid) begin
                    cmd_d  = CMD_WR_K;
                    inp0_d = addr;
                    inp1_d = s_data;
                    row_d  = row_adv;
                    word_d = word_adv;
                    // Input buffer addressing restarts at row 0.
                    if (last_word && row_q == KERN_LAST) begin
                        row_d   = '0;
                        state_d = S_HEAD;
                    end
                end
            end
            S_HEAD: begin
                cmd_d  = CMD_WR_IN;
                inp0_d = addr;
                row_d  = row_adv;
                word_d = word_adv;
                if (last_word && row_q == HEAD_LAST) state_d = S_INPUT;
            end
            S_INPUT: begin
                if (s_valid) begin
                    cmd_d  = CMD_WR_IN;
                    inp0_d = addr;
                    inp1_d = s_data;
                    row_d  = row_adv;
                    word_d = word_adv;
                    if (last_word && row_q == in_last) state_d = S_TAIL;
                end
            end
            S_TAIL: begin
                cmd_d  = CMD_WR_IN;
                inp0_d = addr;
                row_d  = row_adv;
                word_d = word_adv;
                if (last_word && row_q == tail_last) state_d = S_BIAS;
            end
            S_BIAS: begin
                cmd_d   = CMD_BIAS;
                inp0_d  = bias_q;
                state_d = S_OFFSET;
            end
            S_OFFSET: begin
                cmd_d   = CMD_OFFSET;
                inp0_d  = offset_q;
                state_d = S_START;
            end
            S_START: begin
                cmd_d   = CMD_START;
                k_d     = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cu_valid_in) state_d = S_RDREQ;
            end
            S_RDREQ: begin
                cmd_d   = CMD_RD;
                inp0_d  = 32'({k_q, 2'b00});
                state_d = S_RDCAP;
            end
            S_RDCAP: begin
                // The read command is on the bus this cycle; cu_ret carries
                // its data by the end of the cycle.
                m_data_d  = cu_ret;
                m_valid_d = 1'b1;
                state_d   = S_HOLD;
            end
            S_HOLD: begin
                if (m_ready) begin
                    m_valid_d = 1'b0;
                    k_d       = k_next[LEN_W-1:0];
                    state_d   = (k_next < nreads) ? S_RDREQ : S_DONE;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            row_q     <= '0;
            word_q    <= '0;
            k_q       <= '0;
            len_q     <= '0;
            words_q   <= '0;
            bias_q    <= '0;
            offset_q  <= '0;
            cmd_q     <= CMD_NOP;
            inp0_q    <= '0;
            inp1_q    <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            word_q    <= word_d;
            k_q       <= k_d;
            len_q     <= len_d;
            words_q   <= words_d;
            bias_q    <= bias_d;
            offset_q  <= offset_d;
            cmd_q     <= cmd_d;
            inp0_q    <= inp0_d;
            inp1_q    <= inp1_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
        end
    end

    assign s_ready = (state_q == S_KERNEL) || (state_q == S_INPUT);
    assign cu_cmd  = cmd_q;
    assign cu_inp0 = inp0_q;
    assign cu_inp1 = inp1_q;
    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign busy    = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done    = (state_q == S_DONE);

endmodule

// File: tb/tb_conv1d_cmd_sequencer.sv
// Bench for conv1d_cmd_sequencer: a small conv1d stand-in stores the written
// buffers and produces results; every run is compared against a command list
// and result words derived directly from the source data.
module tb_conv1d_cmd_sequencer;
    localparam int KL = 8, P = 4, RS = 128, LW = 11;

    logic clk = 0, reset_n = 0, go = 0;
    logic [LW-1:0] cfg_len = '0;
    logic [5:0] cfg_words = '0;
    logic [31:0] cfg_bias = '0, cfg_offset = '0;
    logic s_valid = 0, s_ready;
    logic [31:0] s_data = '0;
    logic [6:0] cu_cmd;
    logic [31:0] cu_inp0, cu_inp1, cu_ret, m_data;
    logic cu_valid_in, m_valid, m_ready = 0, busy, done;

    always #5 clk = ~clk;

    conv1d_cmd_sequencer #(.KERNEL_LEN(KL), .PAD(P), .ROW_STRIDE(RS), .LEN_W(LW)) dut (
        .clk(clk), .reset_n(reset_n), .go(go), .cfg_len(cfg_len), .cfg_words(cfg_words),
        .cfg_bias(cfg_bias), .cfg_offset(cfg_offset), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .cu_cmd(cu_cmd), .cu_inp0(cu_inp0), .cu_inp1(cu_inp1),
        .cu_valid_in(cu_valid_in), .cu_ret(cu_ret), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .busy(busy), .done(done));

    int n_chk = 0, n_fail = 0;

    // Test configuration and source words (kernel words first, then input).
    int t_len, t_words, t_vd;
    logic [31:0] t_bias, t_off;
    logic [31:0] src[0:255];

    typedef struct { logic [6:0] cmd; logic [31:0] a0; logic [31:0] a1; int cyc; } cmd_t;
    cmd_t log_q[$], exp_q[$];
    logic [31:0] res_q[$], save_q[$];
    int done_cnt, hs0_cyc, extra_evt;

    // ---------------- conv1d stand-in ----------------
    logic [31:0] kmem[0:255], imem[0:1023], outw[0:63];
    logic [31:0] fbias, foff;
    int vcnt;
    logic fvalid;
    assign cu_valid_in = fvalid;
    assign cu_ret = (cu_cmd == 7'd3) ? outw[cu_inp0[7:2]] : 32'h0;

    function automatic int dotw(input logic [31:0] x, input logic [31:0] kv, input int off);
        int s;
        s = 0;
        for (int b = 0; b < 4; b++)
            s += (int'($signed(x[8*b +: 8])) + off) * int'($signed(kv[8*b +: 8]));
        return s;
    endfunction

    function automatic logic [31:0] fake_word(input int k);
        logic [31:0] r;
        int acc, j;
        r = '0;
        for (int b = 0; b < 4; b++) begin
            j = 4*k + b;
            if (j < t_len) begin
                acc = int'(fbias);
                for (int t = 0; t < KL; t++)
                    for (int w = 0; w < t_words; w++)
                        acc += dotw(imem[(j+t)*32 + w], kmem[t*32 + w], int'(foff));
                r[8*b +: 8] = 8'(acc);
            end
        end
        return r;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fvalid <= 1'b0;
            vcnt <= 0;
        end else begin
            case (cu_cmd)
                7'd1: begin imem[cu_inp0[11:2]] <= cu_inp1; fvalid <= 1'b0; end
                7'd2: begin kmem[cu_inp0[9:2]] <= cu_inp1; fvalid <= 1'b0; end
                7'd7: begin fbias <= cu_inp0; fvalid <= 1'b0; end
                7'd8: begin foff <= cu_inp0; fvalid <= 1'b0; end
                7'd4: begin
                    for (int k = 0; k < 64; k++) outw[k] <= fake_word(k);
                    vcnt <= t_vd;
                    fvalid <= 1'b0;
                end
                default: if (vcnt != 0) begin
                    vcnt <= vcnt - 1;
                    if (vcnt == 1) fvalid <= 1'b1;
                end
            endcase
        end
    end

    // ---------------- reference model ----------------
    function automatic logic [31:0] inrow(input int r, input int w);
        if (r < P || r >= P + t_len) return 32'h0;
        return src[KL*t_words + (r-P)*t_words + w];
    endfunction

    function automatic logic [31:0] ref_word(input int k);
        logic [31:0] r;
        int acc, j;
        r = '0;
        for (int b = 0; b < 4; b++) begin
            j = 4*k + b;
            if (j < t_len) begin
                acc = int'(t_bias);
                for (int t = 0; t < KL; t++)
                    for (int w = 0; w < t_words; w++)
                        acc += dotw(inrow(j+t, w), src[t*t_words + w], int'(t_off));
                r[8*b +: 8] = 8'(acc);
            end
        end
        return r;
    endfunction

    task automatic push_exp(input logic [6:0] c, input int a0, input logic [31:0] a1);
        cmd_t e;
        e.cmd = c; e.a0 = a0; e.a1 = a1; e.cyc = 0;
        exp_q.push_back(e);
    endtask

    task automatic gen_data(input int len, input int words);
        t_len = len; t_words = words;
        t_bias = $urandom; t_off = $urandom_range(0, 255) - 128;
        for (int i = 0; i < (KL + len) * words; i++) src[i] = $urandom;
    endtask

    // Runs one sequence. abort: 0 none, 1 reset during INPUT, 2 reset in HOLD.
    task automatic run_seq(input int stall, input int mhold, input int vd, input int gobusy,
                           input int abort);
        int sidx, n_src, nwr1, mv_first;
        bit ps_acc, pm_acc, pm_hold, fin, aborted;
        logic [31:0] pm_data;
        cmd_t e;
        log_q.delete(); res_q.delete();
        done_cnt = 0; hs0_cyc = -1; extra_evt = 0; t_vd = vd;
        n_src = (KL + t_len) * t_words;
        sidx = 0; nwr1 = 0; mv_first = 0;
        ps_acc = 0; pm_acc = 0; pm_hold = 0; fin = 0; aborted = 0; pm_data = '0;
        @(posedge clk); #1;
        go = 1; cfg_len = LW'(t_len); cfg_words = 6'(t_words); cfg_bias = t_bias; cfg_offset = t_off;
        for (int cyc = 0; cyc < 4000 && !fin; cyc++) begin
            @(posedge clk); #1;
            if (ps_acc) sidx++;
            if (pm_acc) begin
                res_q.push_back(pm_data);
                if (res_q.size() == 1) hs0_cyc = cyc;
            end
            if (pm_hold) begin
                n_chk++;
                if (m_valid !== 1'b1 || m_data !== pm_data) begin
                    n_fail++;
                    $display("FAIL m_hold: m_valid=%b m_data=%h, required 1 and %h", m_valid, m_data, pm_data);
                end
            end
            if (cu_cmd != 7'd0) begin
                e.cmd = cu_cmd; e.a0 = cu_inp0; e.a1 = cu_inp1; e.cyc = cyc;
                log_q.push_back(e);
                if (cu_cmd == 7'd1) nwr1++;
            end
            if (done) begin done_cnt++; fin = 1; end
            if ((abort == 1 && nwr1 == P*t_words + 2) || (abort == 2 && m_valid)) begin
                aborted = 1;
                break;
            end
            go = 0;
            cfg_len = LW'($urandom); cfg_words = 6'($urandom); cfg_bias = $urandom; cfg_offset = $urandom;
            if (gobusy && (cyc == 10 || cyc == 25) && busy) go = 1;
            s_valid = (sidx < n_src) ? (stall ? 1'($urandom_range(0, 1)) : 1'b1) : 1'b1;
            s_data = (sidx < n_src) ? src[sidx] : (32'hBAD00000 | 32'(cyc));
            if (mhold && res_q.size() == 0 && m_valid && mv_first < 10) begin
                m_ready = 0; mv_first++;
            end else m_ready = 1;
            ps_acc = s_valid && s_ready;
            pm_acc = m_valid && m_ready;
            pm_hold = m_valid && !m_ready;
            pm_data = m_data;
        end
        go = 0; s_valid = 0;
        if (aborted) begin
            reset_n = 0;
            #1;
            n_chk++;
            if ({cu_cmd, cu_inp0, cu_inp1, s_ready, m_valid, m_data, busy, done} !== '0) begin
                n_fail++;
                $display("FAIL abort%0d_outputs: cmd=%0d inp0=%h inp1=%h s_ready=%b m_valid=%b m_data=%h busy=%b done=%b, required all 0",
                         abort, cu_cmd, cu_inp0, cu_inp1, s_ready, m_valid, m_data, busy, done);
            end
            repeat (3) @(posedge clk);
            @(negedge clk) reset_n = 1;
            repeat (3) begin
                @(posedge clk); #1;
                n_chk++;
                if (cu_cmd !== 7'd0 || busy !== 1'b0 || s_ready !== 1'b0 || m_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL abort%0d_idle: cmd=%0d busy=%b s_ready=%b m_valid=%b, required 0 0 0 0",
                             abort, cu_cmd, busy, s_ready, m_valid);
                end
            end
        end else begin
            n_chk++;
            if (!fin) begin
                n_fail++;
                $display("FAIL timeout: done not seen within 4000 cycles, required done");
            end
            repeat (6) begin
                @(posedge clk); #1;
                if (cu_cmd != 7'd0 || done) extra_evt++;
            end
        end
    endtask

    // Compares the last run against the model.
    task automatic check_run(input string tag);
        int nrd, n1, n2, c4, c3a, c3b;
        nrd = (t_len + 3) / 4;
        exp_q.delete();
        for (int r = 0; r < KL; r++)
            for (int w = 0; w < t_words; w++) push_exp(7'd2, r*RS + 4*w, src[r*t_words + w]);
        for (int r = 0; r < 2*P + t_len; r++)
            for (int w = 0; w < t_words; w++) push_exp(7'd1, r*RS + 4*w, inrow(r, w));
        push_exp(7'd7, int'(t_bias), 0);
        push_exp(7'd8, int'(t_off), 0);
        push_exp(7'd4, 0, 0);
        for (int k = 0; k < nrd; k++) push_exp(7'd3, 4*k, 0);

        n_chk++;
        if (log_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL %s cmd_count: got %0d commands, required %0d", tag, log_q.size(), exp_q.size());
        end
        for (int i = 0; i < log_q.size() && i < exp_q.size(); i++) begin
            bit bad;
            bad = (log_q[i].cmd !== exp_q[i].cmd);
            if (exp_q[i].cmd != 7'd4 && log_q[i].a0 !== exp_q[i].a0) bad = 1;
            if ((exp_q[i].cmd == 7'd1 || exp_q[i].cmd == 7'd2) && log_q[i].a1 !== exp_q[i].a1) bad = 1;
            n_chk++;
            if (bad) begin
                n_fail++;
                $display("FAIL %s cmd[%0d]: got cmd=%0d inp0=%0d inp1=%h, required cmd=%0d inp0=%0d inp1=%h",
                         tag, i, log_q[i].cmd, log_q[i].a0, log_q[i].a1, exp_q[i].cmd, exp_q[i].a0, exp_q[i].a1);
            end
        end
        n1 = 0; n2 = 0; c4 = -1; c3a = -1; c3b = -1;
        foreach (log_q[i]) begin
            if (log_q[i].cmd == 7'd1) n1++;
            if (log_q[i].cmd == 7'd2) n2++;
            if (log_q[i].cmd == 7'd4) c4 = log_q[i].cyc;
            if (log_q[i].cmd == 7'd3) begin
                if (c3a < 0) c3a = log_q[i].cyc;
                else if (c3b < 0) c3b = log_q[i].cyc;
            end
        end
        n_chk++;
        if (n2 != KL*t_words || n1 != (2*P + t_len)*t_words) begin
            n_fail++;
            $display("FAIL %s write_counts: kernel=%0d input=%0d, required %0d %0d",
                     tag, n2, n1, KL*t_words, (2*P + t_len)*t_words);
        end
        n_chk++;
        if (c4 < 0 || c3a - c4 <= t_vd) begin
            n_fail++;
            $display("FAIL %s wait_gap: first read %0d cycles after start, required > %0d", tag, c3a - c4, t_vd);
        end
        n_chk++;
        if (res_q.size() != nrd) begin
            n_fail++;
            $display("FAIL %s result_count: got %0d, required %0d", tag, res_q.size(), nrd);
        end
        for (int k = 0; k < res_q.size() && k < nrd; k++) begin
            n_chk++;
            if (res_q[k] !== ref_word(k)) begin
                n_fail++;
                $display("FAIL %s m_data[%0d]: got %h, required %h", tag, k, res_q[k], ref_word(k));
            end
        end
        n_chk++;
        if (done_cnt != 1 || extra_evt != 0) begin
            n_fail++;
            $display("FAIL %s done_once: done=%0d trailing_events=%0d, required 1 and 0", tag, done_cnt, extra_evt);
        end
        if (nrd > 1) begin
            n_chk++;
            if (c3b < hs0_cyc + 1) begin
                n_fail++;
                $display("FAIL %s read_after_hs: second read cycle %0d, required >= %0d", tag, c3b, hs0_cyc + 1);
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_n = 0;
        repeat (3) @(posedge clk);
        #1;
        n_chk++;
        if ({cu_cmd, cu_inp0, cu_inp1, s_ready, m_valid, m_data, busy, done} !== '0) begin
            n_fail++;
            $display("FAIL reset_values: cmd=%0d inp0=%h inp1=%h s_ready=%b m_valid=%b m_data=%h busy=%b done=%b, required all 0",
                     cu_cmd, cu_inp0, cu_inp1, s_ready, m_valid, m_data, busy, done);
        end
        @(negedge clk) reset_n = 1;
        @(posedge clk); #1;
        n_chk++;
        if (busy !== 1'b0 || s_ready !== 1'b0 || cu_cmd !== 7'd0) begin
            n_fail++;
            $display("FAIL reset_idle: busy=%b s_ready=%b cmd=%0d, required 0 0 0", busy, s_ready, cu_cmd);
        end
    endtask

    task automatic test_golden();
        logic [31:0] iv[8];
        iv = '{32'h07, 32'h0106, 32'h0205, 32'h0304, 32'h0403, 32'h0502, 32'h0601, 32'h0700};
        t_len = 8; t_words = 1; t_bias = 32'd1; t_off = 32'd0;
        for (int i = 0; i < KL; i++) src[i] = 32'h00000102;
        for (int i = 0; i < 8; i++) src[KL + i] = iv[i];
        run_seq(0, 0, 3, 0, 0);
        check_run("golden");
    endtask

    task automatic test_words2();
        gen_data(4, 2);
        run_seq(0, 0, 2, 0, 0);
        check_run("words2");
    endtask

    task automatic test_stall();
        gen_data($urandom_range(5, 12), $urandom_range(1, 3));
        run_seq(0, 0, 2, 0, 0);
        check_run("nostall");
        save_q = res_q;
        run_seq(1, 0, 2, 0, 0);
        check_run("stall");
        n_chk++;
        if (save_q != res_q) begin
            n_fail++;
            $display("FAIL stall_equal: stalled run results differ from stall-free run (%0d vs %0d words)",
                     res_q.size(), save_q.size());
        end
    endtask

    task automatic test_mready_hold();
        gen_data(8, 1);
        run_seq(0, 1, 20, 0, 0);
        check_run("mhold");
        n_chk++;
        if (hs0_cyc < 0 || hs0_cyc - log_q[log_q.size()-2].cyc < 10) begin
            n_fail++;
            $display("FAIL mhold_duration: first handshake at %0d, required >= 10 cycles after first read", hs0_cyc);
        end
    endtask

    task automatic test_reset_mid();
        gen_data(6, 2);
        run_seq(0, 0, 2, 0, 1);
        gen_data(7, 1);
        run_seq(0, 0, 2, 0, 0);
        check_run("after_abort_input");
        gen_data(6, 1);
        run_seq(0, 0, 2, 0, 2);
        gen_data(5, 2);
        run_seq(1, 0, 4, 0, 0);
        check_run("after_abort_hold");
    endtask

    task automatic test_go_busy_len5();
        gen_data(5, 2);
        run_seq(0, 0, 3, 1, 0);
        check_run("gobusy_len5");
    endtask

    task automatic test_random();
        for (int n = 0; n < 3; n++) begin
            gen_data($urandom_range(1, 16), $urandom_range(1, 4));
            run_seq($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(1, 6), 0, 0);
            check_run("random");
        end
    endtask

    initial begin
        test_reset();
        test_golden();
        test_words2();
        test_stall();
        test_mready_hold();
        test_reset_mid();
        test_go_busy_len5();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/conv1d_cmd_sequencer.md
Name: conv1d_cmd_sequencer

Overview:
- Hardware initiator for the conv1d CFU command port. It replaces CPU-issued custom instructions with an autonomous load/compute/drain sequence.
- Accepts kernel and input words on a ready/valid stream, issues every write, config, start and read command, and returns packed output words on a ready/valid result stream.
- Sits between a DMA/stream source and one conv1d instance; its cmd/inp0/inp1 outputs drive conv1d directly.

Parameters:
KERNEL_LEN, 8, kernel taps (kernel buffer rows written)
PAD, 4, zero rows written before and after input data
ROW_STRIDE, 128, address stride per row (max input channels)
LEN_W, 11, width of cfg_len (max input length 1024)

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
go  in  1  single-cycle start pulse; sampled only in IDLE
cfg_len  in  LEN_W  input length in rows, 1..1024
cfg_words  in  6  32-bit words per row (channels/4), 1..32
cfg_bias  in  32  bias value for cmd 7
cfg_offset  in  32  input offset for cmd 8
s_valid  in  1  source word valid
s_ready  out  1  source word accepted this cycle
s_data  in  32  four packed int8; kernel words first, then input words, row-major
cu_cmd  out  7  conv1d cmd
cu_inp0  out  32  conv1d inp0
cu_inp1  out  32  conv1d inp1
cu_valid_in  in  1  conv1d output_buffer_valid
cu_ret  in  32  conv1d ret
m_valid  out  1  result word valid
m_ready  in  1  result word accepted
m_data  out  32  result word (four packed outputs)
busy  out  1  high from go until DONE
done  out  1  one-cycle pulse when the last result word is accepted

Behaviour:
- Reset values: cu_cmd=0, cu_inp0=0, cu_inp1=0, s_ready=0, m_valid=0, m_data=0, busy=0, done=0. All state returns to IDLE. Reset mid-sequence aborts immediately; no further commands are issued.
- All cu_* outputs are registered. cmd=0 is a NOP and is driven in every cycle not listed below.
- Address = row*ROW_STRIDE + col, with col = 4*word_index. Row and col counters wrap col→0 and row+1 at cfg_words.
- State machine:
  - IDLE: go → KERNEL; latch all cfg_* values; busy=1.
  - KERNEL: s_ready=1. Each accepted word issues cmd=2, inp0=addr, inp1=s_data, for rows 0..KERNEL_LEN-1. After the last word → HEAD. With no s_valid, issue NOP and hold the counters.
  - HEAD: no stream traffic. Issue cmd=1, inp1=0 for rows 0..PAD-1, one per cycle → INPUT.
  - INPUT: s_ready=1. Each accepted word issues cmd=1, inp1=s_data, for rows PAD..PAD+len-1 → TAIL.
  - TAIL: issue cmd=1, inp1=0 for rows PAD+len..2*PAD+len-1 → BIAS.
  - BIAS: cmd=7, inp0=cfg_bias, one cycle → OFFSET.
  - OFFSET: cmd=8, inp0=cfg_offset, one cycle → START.
  - START: cmd=4, one cycle → WAIT.
  - WAIT: NOP until cu_valid_in=1 → RDREQ.
  - RDREQ: cmd=3, inp0=4*k, k = result index from 0 → RDCAP.
  - RDCAP: NOP. Capture cu_ret (valid one cycle after the read command) into m_data; set m_valid=1 → HOLD.
  - HOLD: hold m_data until m_ready. On the handshake, k+1: if k+1 < ceil(cfg_len/4) → RDREQ; else → DONE.
  - DONE: done=1 and busy=0 for one cycle → IDLE.
- s_ready is asserted only in KERNEL and INPUT. It deasserts in the cycle after the last word of a phase is accepted. Extra source words are never consumed.
- go while busy is ignored. cfg changes while busy are ignored.
- m_valid is not lowered without a handshake. m_data is stable while m_valid=1 and m_ready=0.
- Total write commands = KERNEL_LEN*cfg_words + (2*PAD+cfg_len)*cfg_words. Total read commands = ceil(cfg_len/4).

Test Plan:
- Case: len=8, words=1, bias=1, offset=0, kernel words 0x00000102 x8, inputs 0x07, 0x0106, 0x0205, 0x0304, 0x0403, 0x0502, 0x0601, 0x0700, with a conv1d golden model attached. Required: 8 cmd=2 at inp0=0,128,..,896; cmd=1 zeros at rows 0-3 and 12-15, data at rows 4-11 (inp0=512..1408); then cmd 7 (inp0=1), cmd 8, cmd 4; cmd=3 at inp0=0 and 4; two m_data words equal to the model output; done pulses once.
- Case: words=2, len=4. Required: inp0 sequence row*128+{0,4} across all phases; 16 kernel writes and 24 input writes total.
- Case: s_valid toggled at random 50% in KERNEL and INPUT. Required: NOP cycles inserted, no duplicate or skipped address, same m_data as the stall-free run.
- Case: m_ready held low 10 cycles on the first result. Required: m_data stable, no second cmd=3 until the handshake; cu_valid_in delayed 20 cycles after start → only NOPs in WAIT.
- Case: reset_n low during INPUT and during HOLD. Required: all outputs read 0 immediately; after release, IDLE; a new go runs a full correct sequence.
- Case: go pulsed while busy, and len=5. Required: the pulse is ignored; the len=5 run issues 2 reads (inp0=0,4).
